mem_port_arbiter: RTL

//  Shares the single external memory port between instruction fetch (IF) and data access (DM, load/store).

---
 rtl/riscv_pkg.sv | 13 +
 rtl/mem_watchdog.sv | 30 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared width constants and memory-arbiter state encoding
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        MARB_IDLE = 2'd0,
        MARB_IF   = 2'd1,
        MARB_DM   = 2'd2
    } marb_state_e;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - busy-cycle counter that flags a stalled memory transaction
module mem_watchdog #(
    parameter int TMO_CYC = 255
) (
    input  logic iClk,
    input  logic nRst,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count value k-1 during the k-th busy cycle, so expiry lands on busy cycle TMO_CYC.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_run && (r_cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - data-over-fetch arbiter for the single memory port
// Optional watchdog abort enabled by MEMARB_TIMEOUT_EN.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = XLEN,
    parameter int DATA_W  = XLEN,
    parameter int TMO_CYC = 255
) (
    input  logic                iClk,
    input  logic                nRst,
    input  logic                iIF_Req,
    input  logic [ADDR_W-1:0]   iIF_Addr,
    output logic                oIF_Rdy,
    output logic [DATA_W-1:0]   oIF_Data,
    input  logic                iDM_Req,
    input  logic                iDM_We,
    input  logic [ADDR_W-1:0]   iDM_Addr,
    input  logic [DATA_W-1:0]   iDM_WData,
    input  logic [DATA_W/8-1:0] iDM_BE,
    output logic                oDM_Rdy,
    output logic [DATA_W-1:0]   oDM_RData,
    output logic                oMem_Req,
    output logic                oMem_We,
    output logic [ADDR_W-1:0]   oMem_Addr,
    output logic [DATA_W-1:0]   oMem_WData,
    output logic [DATA_W/8-1:0] oMem_BE,
    input  logic                iMem_Ack,
    input  logic [DATA_W-1:0]   iMem_RData,
    output logic                oBusErr
);

    marb_state_e         r_state;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W/8-1:0] r_mem_be;
    logic                r_if_rdy;
    logic [DATA_W-1:0]   r_if_data;
    logic                r_dm_rdy;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_bus_err;

    logic w_if_elig;
    logic w_dm_elig;
    logic w_grant;
    logic w_expire;

    // A port pulsing Rdy still holds its old Req this cycle; masking it prevents a re-issue.
    assign w_if_elig = iIF_Req && !r_if_rdy;
    assign w_dm_elig = iDM_Req && !r_dm_rdy;
    assign w_grant   = (r_state == MARB_IDLE) && (w_if_elig || w_dm_elig);

`ifdef MEMARB_TIMEOUT_EN
    mem_watchdog #(
        .TMO_CYC (TMO_CYC)
    ) u_watchdog (
        .iClk     (iClk),
        .nRst     (nRst),
        .i_clr    (w_grant),
        .i_run    (r_state != MARB_IDLE),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= MARB_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_rdy    <= 1'b0;
            r_if_data   <= '0;
            r_dm_rdy    <= 1'b0;
            r_dm_rdata  <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_rdy  <= 1'b0;
            r_dm_rdy  <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                MARB_IDLE: begin
                    if (w_dm_elig) begin
                        r_state     <= MARB_DM;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= iDM_We;
                        r_mem_addr  <= iDM_Addr;
                        r_mem_wdata <= iDM_WData;
                        r_mem_be    <= iDM_BE;
                    end else if (w_if_elig) begin
                        r_state     <= MARB_IF;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= iIF_Addr;
                        r_mem_wdata <= '0;
                        r_mem_be    <= '1;
                    end
                end
                MARB_IF: begin
                    if (iMem_Ack || w_expire) begin
                        r_state   <= MARB_IDLE;
                        r_mem_req <= 1'b0;
                        r_if_rdy  <= 1'b1;
                        r_bus_err <= !iMem_Ack;
                        if (iMem_Ack) begin
                            r_if_data <= iMem_RData;
                        end
                    end
                end
                MARB_DM: begin
                    if (iMem_Ack || w_expire) begin
                        r_state   <= MARB_IDLE;
                        r_mem_req <= 1'b0;
                        r_dm_rdy  <= 1'b1;
                        r_bus_err <= !iMem_Ack;
                        if (iMem_Ack && !r_mem_we) begin
                            r_dm_rdata <= iMem_RData;
                        end
                    end
                end
                default: begin
                    r_state   <= MARB_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign oMem_Req   = r_mem_req;
    assign oMem_We    = r_mem_we;
    assign oMem_Addr  = r_mem_addr;
    assign oMem_WData = r_mem_wdata;
    assign oMem_BE    = r_mem_be;
    assign oIF_Rdy    = r_if_rdy;
    assign oIF_Data   = r_if_data;
    assign oDM_Rdy    = r_dm_rdy;
    assign oDM_RData  = r_dm_rdata;
    assign oBusErr    = r_bus_err;

endmodule
